// File: rtl/dma_bus_arbiter_pkg.sv
// dma_bus_arbiter_pkg
//   Shared definitions for the DMA bus arbiter: FSM state encodings,
//   default parameter values and the "no grant" vector value.
//   No ports (package).

package dma_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_CPU_OWN   = 3'd0,
        ARB_HALT_WAIT = 3'd1,
        ARB_GRANT     = 3'd2,
        ARB_REARB     = 3'd3,
        ARB_RELEASE   = 3'd4
    } arb_state_e;

    localparam int DEF_MAX_BURST   = 8;
    localparam int DEF_ACK_TIMEOUT = 15;

    // Grant vector while the CPU owns the bus (wide enough for NREQ <= 8).
    localparam logic [7:0] GRANT_NONE = 8'h00;

endpackage

// File: rtl/dma_bus_arbiter_rr_pick.sv
// dma_bus_arbiter_rr_pick
//   Combinational round-robin priority picker. Returns the first set bit of
//   req scanning upward from ptr with wrap-around.
// Ports:
//   req    in  NREQ          request vector
//   ptr    in  clog2(NREQ)   highest-priority index for this pick
//   winner out clog2(NREQ)   selected index (0 when no request)
//   valid  out 1             at least one request present

module dma_bus_arbiter_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic                    valid
);

    localparam int IDW = $clog2(NREQ);

    int j;

    // Scan from the farthest offset down to offset 0 so the last hit written
    // is the one closest to ptr.
    always_comb begin
        winner = '0;
        valid  = |req;
        j      = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NREQ;
            if (req[j]) winner = IDW'(j);
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
//   Shares the CPU external bus between the 6502 core and NREQ DMA
//   requesters. Halts the core, waits for its halted acknowledge, grants the
//   bus round-robin with a per-grant burst limit, and hands the bus back to
//   the CPU when no requests remain. All outputs are registered.
// Optional build macro: DMA_BUS_ARBITER_WATCHDOG_EN
//   Enables a halt_ack timeout in HALT_WAIT / RELEASE with a sticky arb_err.
//   Without it, waits are unbounded and arb_err is tied 0.
// Ports:
//   fclk        in  1            system clock
//   RES_L       in  1            async active-low reset
//   dma_req     in  NREQ         level requests, held until done
//   dma_done    in  NREQ         one-cycle completion pulses
//   halt_ack    in  1            core is halted
//   HALT        out 1            stall request to the core
//   dma_grant   out NREQ         one-hot grant, 0 when CPU owns the bus
//   bus_sel_dma out 1            1 = DMA drives address/R/W
//   active_id   out clog2(NREQ)  granted requester index, 0 when idle
//   arb_err     out 1            sticky halt-ack timeout flag

module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                    fclk,
    input  logic                    RES_L,
    input  logic [NREQ-1:0]         dma_req,
    input  logic [NREQ-1:0]         dma_done,
    input  logic                    halt_ack,
    output logic                    HALT,
    output logic [NREQ-1:0]         dma_grant,
    output logic                    bus_sel_dma,
    output logic [$clog2(NREQ)-1:0] active_id,
    output logic                    arb_err
);

    localparam int IDW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic            halt_q, halt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            bus_sel_q, bus_sel_d;
    logic [IDW-1:0]  active_id_q, active_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]      burst_q, burst_d;
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
    logic [7:0]      wd_q, wd_d;
    logic            arb_err_q, arb_err_d;
`endif

    logic [IDW-1:0]  pick_id;
    logic            pick_valid;
    logic            done_hit, req_gone, burst_hit, grant_exit;
    logic [NREQ-1:0] clear_mask;
    logic            pending;
    logic [IDW-1:0]  next_ptr;

    dma_bus_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req    (dma_req),
        .ptr    (rr_ptr_q),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q;
        grant_d     = grant_q;
        bus_sel_d   = bus_sel_q;
        active_id_d = active_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_d     = burst_q;
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
        wd_d        = '0;            // counts only while a wait branch holds it
        arb_err_d   = arb_err_q;
`endif

        done_hit   = dma_done[active_id_q];
        req_gone   = !dma_req[active_id_q];
        burst_hit  = (burst_q == 8'(MAX_BURST - 1));
        grant_exit = done_hit || req_gone || burst_hit;
        // A requester that finished or withdrew is not "pending"; one cut off
        // by the burst limit still is and competes again after REARB.
        clear_mask = (done_hit || req_gone) ? (NREQ'(1) << active_id_q) : '0;
        pending    = |(dma_req & ~clear_mask);
        next_ptr   = (active_id_q == IDW'(NREQ - 1)) ? '0 : active_id_q + IDW'(1);

        case (state_q)
            ARB_CPU_OWN: begin
                if (|dma_req) begin
                    state_d = ARB_HALT_WAIT;
                    halt_d  = 1'b1;
                end
            end

            ARB_HALT_WAIT: begin
                if (halt_ack) begin
                    if (pick_valid) begin
                        state_d     = ARB_GRANT;
                        grant_d     = NREQ'(1) << pick_id;
                        bus_sel_d   = 1'b1;
                        active_id_d = pick_id;
                        burst_d     = '0;
                    end else begin
                        state_d = ARB_RELEASE;
                        halt_d  = 1'b0;
                    end
                end else if (!(|dma_req)) begin
                    state_d = ARB_RELEASE;
                    halt_d  = 1'b0;
                end
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
                else begin
                    wd_d = wd_q + 8'd1;
                    // Flag rises one cycle ahead of the forced exit so it is
                    // visible on the last waited cycle.
                    if (int'(wd_q) + 2 >= ACK_TIMEOUT) arb_err_d = 1'b1;
                    if (int'(wd_q) + 1 >= ACK_TIMEOUT) begin
                        state_d = ARB_CPU_OWN;
                        halt_d  = 1'b0;
                    end
                end
`endif
            end

            ARB_GRANT: begin
                burst_d = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
                if (grant_exit) begin
                    grant_d     = GRANT_NONE[NREQ-1:0];
                    bus_sel_d   = 1'b0;
                    active_id_d = '0;
                    rr_ptr_d    = next_ptr;
                    if (pending) begin
                        state_d = ARB_REARB;
                    end else begin
                        state_d = ARB_RELEASE;
                        halt_d  = 1'b0;
                    end
                end
            end

            ARB_REARB: begin
                if (pick_valid) begin
                    state_d     = ARB_GRANT;
                    grant_d     = NREQ'(1) << pick_id;
                    bus_sel_d   = 1'b1;
                    active_id_d = pick_id;
                    burst_d     = '0;
                end else begin
                    state_d = ARB_RELEASE;
                    halt_d  = 1'b0;
                end
            end

            ARB_RELEASE: begin
                // Requests are ignored here: the core must see halt_ack low
                // (i.e. run) before it can be halted again.
                if (!halt_ack) begin
                    state_d = ARB_CPU_OWN;
                end
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
                else begin
                    wd_d = wd_q + 8'd1;
                    if (int'(wd_q) + 2 >= ACK_TIMEOUT) arb_err_d = 1'b1;
                    if (int'(wd_q) + 1 >= ACK_TIMEOUT) state_d = ARB_CPU_OWN;
                end
`endif
            end

            default: begin
                state_d     = ARB_CPU_OWN;
                halt_d      = 1'b0;
                grant_d     = GRANT_NONE[NREQ-1:0];
                bus_sel_d   = 1'b0;
                active_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge fclk or negedge RES_L) begin
        if (!RES_L) begin
            state_q     <= ARB_CPU_OWN;
            halt_q      <= 1'b0;
            grant_q     <= GRANT_NONE[NREQ-1:0];
            bus_sel_q   <= 1'b0;
            active_id_q <= '0;
            rr_ptr_q    <= '0;
            burst_q     <= '0;
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
            wd_q        <= '0;
            arb_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            grant_q     <= grant_d;
            bus_sel_q   <= bus_sel_d;
            active_id_q <= active_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_q     <= burst_d;
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
            wd_q        <= wd_d;
            arb_err_q   <= arb_err_d;
`endif
        end
    end

    assign HALT        = halt_q;
    assign dma_grant   = grant_q;
    assign bus_sel_dma = bus_sel_q;
    assign active_id   = active_id_q;
`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
    assign arb_err     = arb_err_q;
`else
    assign arb_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter
//   Directed bench for dma_bus_arbiter (NREQ=4, MAX_BURST=8, ACK_TIMEOUT=15).
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
//   The watchdog sequence runs when DMA_BUS_ARBITER_WATCHDOG_EN is defined.

module tb_dma_bus_arbiter;

    logic       fclk = 1'b0;
    logic       RES_L = 1'b0;
    logic [3:0] dma_req = '0;
    logic [3:0] dma_done = '0;
    logic       halt_ack = 1'b0;
    logic       HALT;
    logic [3:0] dma_grant;
    logic       bus_sel_dma;
    logic [1:0] active_id;
    logic       arb_err;

    int total = 0;
    int bad   = 0;
    int rr_ids [5] = '{0, 1, 2, 3, 0};

    always #5 fclk = ~fclk;

    dma_bus_arbiter #(.NREQ(4), .MAX_BURST(8), .ACK_TIMEOUT(15)) dut (
        .fclk        (fclk),
        .RES_L       (RES_L),
        .dma_req     (dma_req),
        .dma_done    (dma_done),
        .halt_ack    (halt_ack),
        .HALT        (HALT),
        .dma_grant   (dma_grant),
        .bus_sel_dma (bus_sel_dma),
        .active_id   (active_id),
        .arb_err     (arb_err)
    );

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic h, input logic [3:0] g,
                           input logic s, input logic [1:0] id);
        chk({tag, "/HALT"},        32'(HALT),        32'(h));
        chk({tag, "/dma_grant"},   32'(dma_grant),   32'(g));
        chk({tag, "/bus_sel_dma"}, 32'(bus_sel_dma), 32'(s));
        chk({tag, "/active_id"},   32'(active_id),   32'(id));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk_out("reset", 0, 4'b0000, 0, 0);
        chk("reset/arb_err", 32'(arb_err), 32'd0);
        RES_L = 1'b1;
        tick();
        chk_out("idle", 0, 4'b0000, 0, 0);

        // Single request, ack two cycles after HALT
        dma_req = 4'b0010;
        tick(); chk_out("t1_halt", 1, 4'b0000, 0, 0);
        tick(); chk_out("t1_wait", 1, 4'b0000, 0, 0);
        halt_ack = 1'b1;
        tick(); chk_out("t1_grant", 1, 4'b0010, 1, 1);
        tick(); chk_out("t1_hold", 1, 4'b0010, 1, 1);
        dma_done = 4'b0010;
        tick(); dma_done = '0; dma_req = '0;
        chk_out("t1_release", 0, 4'b0000, 0, 0);
        tick(); chk_out("t1_rel_ack_hi", 0, 4'b0000, 0, 0);
        halt_ack = 1'b0;
        tick(); chk_out("t1_cpu", 0, 4'b0000, 0, 0);

        // Reset in the middle of a grant
        dma_req = 4'b0100;
        tick(); chk_out("rst_halt", 1, 4'b0000, 0, 0);
        halt_ack = 1'b1;
        tick(); chk_out("rst_grant", 1, 4'b0100, 1, 2);
        tick();
        RES_L = 1'b0;
        #1;
        chk_out("rst_async", 0, 4'b0000, 0, 0);
        dma_req = '0; halt_ack = 1'b0;
        tick(); RES_L = 1'b1;
        tick(); tick();
        chk_out("rst_idle", 0, 4'b0000, 0, 0);

        // Round robin, all four requesting, done after 2 grant cycles
        dma_req = 4'b1111;
        tick(); chk_out("rr_halt", 1, 4'b0000, 0, 0);
        halt_ack = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk_out("rr_g1", 1, 4'(1 << rr_ids[k]), 1, 2'(rr_ids[k]));
            tick();
            chk_out("rr_g2", 1, 4'(1 << rr_ids[k]), 1, 2'(rr_ids[k]));
            dma_done = 4'(1 << rr_ids[k]);
            if (k == 4) dma_req = '0;
            tick(); dma_done = '0;
            if (k < 4) begin
                chk_out("rr_rearb", 1, 4'b0000, 0, 0);
                tick();
            end
        end
        chk_out("rr_release", 0, 4'b0000, 0, 0);

        // New request in RELEASE while halt_ack still high: no shortcut
        dma_req = 4'b0100;
        tick(); chk_out("ns_rel1", 0, 4'b0000, 0, 0);
        tick(); chk_out("ns_rel2", 0, 4'b0000, 0, 0);
        halt_ack = 1'b0;
        tick(); chk_out("ns_cpu", 0, 4'b0000, 0, 0);
        tick(); chk_out("ns_rehalt", 1, 4'b0000, 0, 0);

        // Burst limit: requester 2 alone, stray done from requester 0 ignored
        halt_ack = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk_out("bl_grant", 1, 4'b0100, 1, 2);
            if (c == 3) dma_done = 4'b0001;
            tick(); dma_done = '0;
        end
        chk_out("bl_rearb", 1, 4'b0000, 0, 0);
        tick(); chk_out("bl_regrant", 1, 4'b0100, 1, 2);

        // Burst expiry coincident with done, requester 0 also waiting
        dma_req = 4'b0101;
        for (int c = 1; c <= 8; c++) begin
            chk_out("bl2_grant", 1, 4'b0100, 1, 2);
            if (c == 8) dma_done = 4'b0100;
            tick(); dma_done = '0;
        end
        dma_req = 4'b0001;
        chk_out("bl2_rearb", 1, 4'b0000, 0, 0);
        tick(); chk_out("bl2_next", 1, 4'b0001, 1, 0);
        dma_done = 4'b0001; dma_req = '0;
        tick(); dma_done = '0;
        chk_out("end_release", 0, 4'b0000, 0, 0);
        halt_ack = 1'b0;
        tick(); chk_out("end_cpu", 0, 4'b0000, 0, 0);

`ifdef DMA_BUS_ARBITER_WATCHDOG_EN
        // halt_ack never arrives
        RES_L = 1'b0; tick(); RES_L = 1'b1; tick();
        dma_req = 4'b0001;
        tick();
        for (int c = 1; c <= 14; c++) begin
            chk("wd_err_low", 32'(arb_err), 32'd0);
            chk("wd_halt_hi", 32'(HALT), 32'd1);
            tick();
        end
        chk("wd_err_c15", 32'(arb_err), 32'd1);
        chk("wd_halt_c15", 32'(HALT), 32'd1);
        tick();
        chk("wd_halt_c16", 32'(HALT), 32'd0);
        chk("wd_err_c16", 32'(arb_err), 32'd1);
        dma_req = '0;
        tick(); tick();
        chk("wd_err_sticky", 32'(arb_err), 32'd1);
        RES_L = 1'b0;
        #1;
        chk("wd_err_reset", 32'(arb_err), 32'd0);
        RES_L = 1'b1;
`else
        chk("no_wd_err", 32'(arb_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
